// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse_meter block.
// Contents: default count width, saturation constant, controller state encoding.
package pulse_meter_pkg;

    localparam int unsigned W_DEF       = 8;
    localparam int unsigned STAR_W      = 3;
    localparam logic [W_DEF-1:0] SAT_MAX_DEF = {W_DEF{1'b1}};

    typedef enum logic [STAR_W-1:0] {
        S_WAIT_LOW = 3'd0,
        S_IDLE     = 3'd1,
        S_COUNT    = 3'd2,
        S_WAIT_RFD = 3'd3,
        S_OFFER    = 3'd4,
        S_RELEASE  = 3'd5
    } star_t;

endpackage

// File: rtl/pulse_meter_sat_inc.sv
// Combinational W-bit saturating incrementer.
// Ports: cnt (current value), cnt_inc (cnt+1, or cnt when cnt is all ones).
module pulse_meter_sat_inc #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] cnt,
    output logic [W-1:0] cnt_inc
);

    assign cnt_inc = (&cnt) ? cnt : cnt + W'(1);

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures the length of an upstream pulse in clock cycles and
// offers the result to a consumer over an rfd/dav handshake (producer side).
// Ports:
//   clock   - system clock, posedge
//   reset_  - asynchronous active-low reset
//   pulse   - input pulse, high = counting
//   rfd     - consumer ready-for-data
//   dav     - data available (registered)
//   z       - measured length, stable while dav=1 (registered)
//   overrun - sticky lost-pulse / saturation flag
// Build option: define PULSE_METER_OVERRUN_EN to implement overrun; otherwise
// it is tied to 0.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         pulse,
    input  logic         rfd,
    output logic         dav,
    output logic [W-1:0] z,
    output logic         overrun
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    star_t        star;
    star_t        star_nxt;
    logic [W-1:0] count;
    logic [W-1:0] count_inc;

    // b-signals: controller -> datapath
    logic b_load1;
    logic b_clear;
    logic b_inc;
    logic b_cap_z;
    logic b_set_dav;
    logic b_clr_dav;

    // c-signals: datapath -> controller
    logic c_max;

    assign c_max = (count == CNT_MAX);

    // ---------------- p_controllo ----------------

    // State register
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            star <= S_WAIT_LOW;
        end else begin
            star <= star_nxt;
        end
    end

    // Next state and b-signal decode
    always_comb begin
        star_nxt  = star;
        b_load1   = 1'b0;
        b_clear   = 1'b0;
        b_inc     = 1'b0;
        b_cap_z   = 1'b0;
        b_set_dav = 1'b0;
        b_clr_dav = 1'b0;
        unique case (star)
            S_WAIT_LOW: begin
                if (!pulse) star_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (pulse) begin
                    b_load1  = 1'b1;
                    star_nxt = S_COUNT;
                end else begin
                    b_clear  = 1'b1;
                end
            end
            S_COUNT: begin
                if (pulse) begin
                    // holding at max keeps the saturated value
                    b_inc = !c_max;
                end else begin
                    b_cap_z  = 1'b1;
                    star_nxt = S_WAIT_RFD;
                end
            end
            S_WAIT_RFD: begin
                if (rfd) begin
                    b_set_dav = 1'b1;
                    star_nxt  = S_OFFER;
                end
            end
            S_OFFER: begin
                if (!rfd) begin
                    b_clr_dav = 1'b1;
                    star_nxt  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (rfd) star_nxt = S_WAIT_LOW;
            end
            default: star_nxt = S_WAIT_LOW;
        endcase
    end

    // ---------------- p_operativa ----------------

    pulse_meter_sat_inc #(
        .W (W)
    ) u_sat_inc (
        .cnt     (count),
        .cnt_inc (count_inc)
    );

    // Count, result and handshake registers
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            count <= '0;
            z     <= '0;
            dav   <= 1'b0;
        end else begin
            if (b_load1) begin
                count <= W'(1);
            end else if (b_clear) begin
                count <= '0;
            end else if (b_inc) begin
                count <= count_inc;
            end
            if (b_cap_z)   z   <= count;
            if (b_set_dav) dav <= 1'b1;
            if (b_clr_dav) dav <= 1'b0;
        end
    end

`ifdef PULSE_METER_OVERRUN_EN
    logic ov_set;

    // Pulse seen while not able to measure, or a pulse longer than the counter
    assign ov_set = (pulse && (star == S_WAIT_RFD || star == S_OFFER ||
                               star == S_RELEASE  || star == S_WAIT_LOW)) ||
                    (star == S_COUNT && pulse && c_max);

    // Sticky overrun flag
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            overrun <= 1'b0;
        end else if (ov_set) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Directed self-checking bench for pulse_meter.
module tb_pulse_meter;

    logic       clock;
    logic       reset_;
    logic       pulse;
    logic       rfd;
    logic       dav;
    logic [7:0] z;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_ov = 1'b0;

    pulse_meter #(.W(8)) dut (
        .clock   (clock),
        .reset_  (reset_),
        .pulse   (pulse),
        .rfd     (rfd),
        .dav     (dav),
        .z       (z),
        .overrun (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic edav, input logic [7:0] ez);
        chk({tag, ".dav"}, 16'(dav), 16'(edav));
        chk({tag, ".z"}, 16'(z), 16'(ez));
    endtask

    // Full measurement with rfd=1 from IDLE, ending back in IDLE.
    task automatic measure(input string tag, input int n, input logic [7:0] ez);
        pulse = 1'b1;
        repeat (n) tick();
        pulse = 1'b0;
        tick();
        chk_out({tag, ".cap"}, 1'b0, ez);
        tick();
        chk_out({tag, ".offer"}, 1'b1, ez);
        rfd = 1'b0;
        tick();
        chk_out({tag, ".release"}, 1'b0, ez);
        rfd = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        reset_ = 1'b0;
        pulse  = 1'b0;
        rfd    = 1'b1;
        tick();
        tick();
        chk_out("reset", 1'b0, 8'd0);
        chk("reset.ov", 16'(overrun), 16'(1'b0));
        reset_ = 1'b1;
        tick();

        // Basic lengths and saturation
        measure("p5", 5, 8'd5);
        measure("p1", 1, 8'd1);
        measure("p255", 255, 8'd255);
        chk("p255.ov", 16'(overrun), 16'(exp_ov));
        measure("p300", 300, 8'd255);
`ifdef PULSE_METER_OVERRUN_EN
        exp_ov = 1'b1;
`endif
        chk("p300.ov", 16'(overrun), 16'(exp_ov));

        // Consumer not ready: value held, dav waits for rfd
        rfd   = 1'b0;
        pulse = 1'b1;
        repeat (7) tick();
        pulse = 1'b0;
        tick();
        chk_out("p7.cap", 1'b0, 8'd7);
        repeat (10) tick();
        chk_out("p7.hold", 1'b0, 8'd7);
        rfd = 1'b1;
        tick();
        chk_out("p7.offer", 1'b1, 8'd7);
        rfd = 1'b0;
        tick();
        chk_out("p7.release", 1'b0, 8'd7);
        rfd = 1'b1;
        tick();
        tick();

        // Reset clears sticky overrun; pulse during offer is ignored
        reset_ = 1'b0;
        #1;
        exp_ov = 1'b0;
        chk_out("rst2", 1'b0, 8'd0);
        chk("rst2.ov", 16'(overrun), 16'(exp_ov));
        tick();
        reset_ = 1'b1;
        tick();
        pulse = 1'b1;
        repeat (6) tick();
        pulse = 1'b0;
        tick();
        tick();
        chk_out("p6.offer", 1'b1, 8'd6);
        pulse = 1'b1;
        repeat (3) tick();
        pulse = 1'b0;
`ifdef PULSE_METER_OVERRUN_EN
        exp_ov = 1'b1;
`endif
        chk_out("busy.pulse", 1'b1, 8'd6);
        chk("busy.ov", 16'(overrun), 16'(exp_ov));
        rfd = 1'b0;
        tick();
        chk_out("p6.release", 1'b0, 8'd6);
        rfd = 1'b1;
        tick();
        tick();
        measure("p2", 2, 8'd2);
        chk("p2.ov_sticky", 16'(overrun), 16'(exp_ov));

        // Pulse already high at reset release is skipped
        reset_ = 1'b0;
        pulse  = 1'b1;
        exp_ov = 1'b0;
        tick();
        reset_ = 1'b1;
        repeat (4) tick();
        pulse = 1'b0;
`ifdef PULSE_METER_OVERRUN_EN
        exp_ov = 1'b1;
`endif
        tick();
        chk_out("skip", 1'b0, 8'd0);
        chk("skip.ov", 16'(overrun), 16'(exp_ov));
        measure("p4", 4, 8'd4);

        // Reset during counting: immediate clear, no later offer
        pulse = 1'b1;
        repeat (3) tick();
        reset_ = 1'b0;
        #1;
        exp_ov = 1'b0;
        chk_out("rst_count", 1'b0, 8'd0);
        pulse = 1'b0;
        tick();
        reset_ = 1'b1;
        repeat (5) tick();
        chk_out("rst_count.after", 1'b0, 8'd0);

        // Reset during offer
        pulse = 1'b1;
        repeat (5) tick();
        pulse = 1'b0;
        tick();
        tick();
        chk_out("p5b.offer", 1'b1, 8'd5);
        reset_ = 1'b0;
        #1;
        chk_out("rst_offer", 1'b0, 8'd0);
        tick();
        reset_ = 1'b1;
        repeat (5) tick();
        chk_out("rst_offer.after", 1'b0, 8'd0);

        // Upstream x=20, y=9 produces a max(x,y)=20 cycle pulse
        measure("chain", 20, 8'd20);
        chk("final.ov", 16'(overrun), 16'(exp_ov));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
